taskwait_stream_arbiter: RTL and testbench

- Merges taskwait-related AXI-Stream messages from NUM_IN producers into the single inStream consumed by the taskwait manager.
- Producers are accelerator taskwait requests and task-finished notifications from the command path.
- Each message is an atomic packet: header beat (components, type) then task-id beat.
- The arbiter never interleaves packets. It grants round-robin and drives a registered output stage.

---
 rtl/taskwait_stream_arbiter.sv | 141 ++++++++++++++
 tb/tb_taskwait_stream_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/taskwait_stream_arbiter.sv
// Round-robin packet arbiter merging NUM_IN taskwait AXI-Stream producers
// into one registered output stream; packets are never interleaved.
module taskwait_stream_arbiter #(
  parameter int NUM_IN  = 2,
  parameter int ID_BITS = 4
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [NUM_IN*64-1:0]        in_TDATA,
  input  logic [NUM_IN*ID_BITS-1:0]   in_TID,
  input  logic [NUM_IN-1:0]           in_TLAST,
  input  logic [NUM_IN-1:0]           in_TVALID,
  output logic [NUM_IN-1:0]           in_TREADY,
  output logic [63:0]                 outStream_TDATA,
  output logic [ID_BITS-1:0]          outStream_TID,
  output logic                        outStream_TLAST,
  output logic                        outStream_TVALID,
  input  logic                        outStream_TREADY,
  output logic                        err_short,
  output logic                        err_long
);
  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              state_q;
  logic [GW-1:0]       grant_q, last_q;
  logic [1:0]          cnt_q;
  logic                out_vld_q, out_last_q, err_short_q, err_long_q;
  logic [63:0]         out_data_q;
  logic [ID_BITS-1:0]  out_tid_q;

  logic                out_free, accept, sel_valid, sel_last;
  logic [63:0]         sel_data;
  logic [ID_BITS-1:0]  sel_tid;
  logic [1:0]          cnt_inc;
  logic                arb_found, hi_found, lo_found;
  logic [GW-1:0]       arb_idx, hi_idx, lo_idx;

  // Mux of the currently granted input
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_tid   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = in_TVALID[i];
        sel_last  = in_TLAST[i];
        sel_data  = in_TDATA[64*i +: 64];
        sel_tid   = in_TID[ID_BITS*i +: ID_BITS];
      end
    end
  end

  // Cyclic scan from last_q+1: lowest valid above last_q, else lowest valid overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_TVALID[i]) begin
        lo_found = 1'b1;
        lo_idx   = GW'(i);
        if (GW'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
    arb_found = lo_found;
    arb_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign out_free = !out_vld_q || outStream_TREADY;
  assign accept   = (state_q == LOCKED) && sel_valid && out_free;
  assign cnt_inc  = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;

  always_comb begin
    in_TREADY = '0;
    if (state_q == LOCKED) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (grant_q == GW'(i)) in_TREADY[i] = out_free;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_IN - 1);
      cnt_q       <= 2'd0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_tid_q   <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      // The output register drains independently of arbitration state
      if (out_free) begin
        out_vld_q <= accept;
        if (accept) begin
          out_data_q <= sel_data;
          out_tid_q  <= sel_tid;
          out_last_q <= sel_last;
        end
      end
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            grant_q <= arb_idx;
            cnt_q   <= 2'd0;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept) begin
            cnt_q <= cnt_inc;
            if (sel_last && cnt_inc == 2'd1)  err_short_q <= 1'b1;
            if (!sel_last && cnt_inc == 2'd2) err_long_q  <= 1'b1;
            if (sel_last) begin
              last_q  <= grant_q;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign outStream_TDATA  = out_data_q;
  assign outStream_TID    = out_tid_q;
  assign outStream_TLAST  = out_last_q;
  assign outStream_TVALID = out_vld_q;
  assign err_short        = err_short_q;
  assign err_long         = err_long_q;
endmodule

// File: tb/tb_taskwait_stream_arbiter.sv
// Directed bench for taskwait_stream_arbiter: per-input beat queues feed the DUT,
// output beats are logged with their cycle and checked against hand-computed values.
module tb_taskwait_stream_arbiter;
  localparam int NUM_IN  = 2;
  localparam int ID_BITS = 4;

  logic                       ap_clk = 1'b0;
  logic                       ap_rst = 1'b1;
  logic [NUM_IN*64-1:0]       in_TDATA = '0;
  logic [NUM_IN*ID_BITS-1:0]  in_TID = '0;
  logic [NUM_IN-1:0]          in_TLAST = '0;
  logic [NUM_IN-1:0]          in_TVALID = '0;
  logic [NUM_IN-1:0]          in_TREADY;
  logic [63:0]                outStream_TDATA;
  logic [ID_BITS-1:0]         outStream_TID;
  logic                       outStream_TLAST;
  logic                       outStream_TVALID;
  logic                       outStream_TREADY = 1'b1;
  logic                       err_short, err_long;

  taskwait_stream_arbiter #(.NUM_IN(NUM_IN), .ID_BITS(ID_BITS)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_TDATA(in_TDATA), .in_TID(in_TID), .in_TLAST(in_TLAST),
    .in_TVALID(in_TVALID), .in_TREADY(in_TREADY),
    .outStream_TDATA(outStream_TDATA), .outStream_TID(outStream_TID),
    .outStream_TLAST(outStream_TLAST), .outStream_TVALID(outStream_TVALID),
    .outStream_TREADY(outStream_TREADY),
    .err_short(err_short), .err_long(err_long)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [63:0]        d;
    logic [ID_BITS-1:0] id;
    logic               last;
    int                 cyc;
  } beat_t;

  beat_t srcq[NUM_IN][$];
  beat_t sb[$];
  bit    rdy_pat[$];
  bit    hs_in[NUM_IN];
  int    cyc = 0;
  int    total = 0;
  int    bad = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  // Producers and downstream ready change 1 time unit after the clock edge
  always @(posedge ap_clk) begin
    #1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (hs_in[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      hs_in[i] = 1'b0;
      if (srcq[i].size() > 0) begin
        in_TVALID[i]                   = 1'b1;
        in_TDATA[64*i +: 64]           = srcq[i][0].d;
        in_TID[ID_BITS*i +: ID_BITS]   = srcq[i][0].id;
        in_TLAST[i]                    = srcq[i][0].last;
      end else begin
        in_TVALID[i] = 1'b0;
        in_TLAST[i]  = 1'b0;
      end
    end
    outStream_TREADY = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
  end

  always @(negedge ap_clk) begin
    for (int i = 0; i < NUM_IN; i++)
      hs_in[i] = !ap_rst && in_TVALID[i] && in_TREADY[i];
    if (!ap_rst && outStream_TVALID && outStream_TREADY)
      sb.push_back('{outStream_TDATA, outStream_TID, outStream_TLAST, cyc});
  end

  task automatic tick();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic push_beat(input int s, input logic [63:0] d,
                           input logic [ID_BITS-1:0] id, input logic last);
    srcq[s].push_back('{d, id, last, 0});
  endtask

  task automatic wait_beats(input int n, input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      if (sb.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    tick();
    ap_rst = 1'b1;
    for (int i = 0; i < NUM_IN; i++) srcq[i].delete();
    rdy_pat.delete();
    tick();
    tick();
    ap_rst = 1'b0;
    sb.delete();
  endtask

  function automatic logic [63:0] hdr(input int s, input int p);
    return 64'h1000 | (64'(s) << 8) | (64'(p) << 4);
  endfunction

  task automatic test_reset();
    ap_rst = 1'b1;
    push_beat(0, 64'h55, 4'h1, 1'b1);
    push_beat(1, 64'h66, 4'h2, 1'b1);
    tick(); tick(); tick();
    total++; if (outStream_TVALID !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", outStream_TVALID); end
    total++; if (in_TREADY !== 2'b00) begin bad++; $display("FAIL reset_tready got=%b exp=00", in_TREADY); end
    total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {err_short, err_long}); end
    do_reset();
  endtask

  task automatic test_single();
    int c; bit ok;
    do_reset();
    c = cyc;
    push_beat(1, 64'h0000_0003_0000_0001, 4'd5, 1'b0);
    push_beat(1, 64'h0000_0000_0000_ABCD, 4'd5, 1'b1);
    wait_beats(2, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout got=%0d beats exp=2", sb.size()); end
    if (ok) begin
      total++; if (sb[0].d !== 64'h0000_0003_0000_0001 || sb[0].id !== 4'd5 || sb[0].last !== 1'b0) begin
        bad++; $display("FAIL single_hdr got=%h/%0d/%b exp=0000000300000001/5/0", sb[0].d, sb[0].id, sb[0].last); end
      total++; if (sb[1].d !== 64'hABCD || sb[1].id !== 4'd5 || sb[1].last !== 1'b1) begin
        bad++; $display("FAIL single_tid got=%h/%0d/%b exp=abcd/5/1", sb[1].d, sb[1].id, sb[1].last); end
      total++; if (sb[0].cyc !== c + 3 || sb[1].cyc !== c + 4) begin
        bad++; $display("FAIL single_latency got=%0d,%0d exp=%0d,%0d", sb[0].cyc - c, sb[1].cyc - c, 3, 4); end
    end
    total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL single_flags got=%b exp=00", {err_short, err_long}); end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < 2; s++) begin
        push_beat(s, hdr(s, p), 4'(s + 2), 1'b0);
        push_beat(s, hdr(s, p) | 64'h1, 4'(s + 2), 1'b1);
      end
    wait_beats(12, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL contention_timeout got=%0d beats exp=12", sb.size()); end
    if (ok) begin
      for (int k = 0; k < 12; k++) begin
        logic [63:0] exp_d;
        exp_d = hdr((k / 2) % 2, k / 4) | 64'(k % 2);
        total++; if (sb[k].d !== exp_d || sb[k].last !== 1'(k % 2)) begin
          bad++; $display("FAIL contention_beat%0d got=%h/%b exp=%h/%b", k, sb[k].d, sb[k].last, exp_d, 1'(k % 2)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int c; bit ok;
    do_reset();
    c = cyc;
    push_beat(0, 64'hB0, 4'd7, 1'b0);
    push_beat(0, 64'hB1, 4'd7, 1'b1);
    rdy_pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tick(); tick(); tick();
    for (int k = 0; k < 2; k++) begin
      total++; if (outStream_TVALID !== 1'b1 || outStream_TDATA !== 64'hB0 || outStream_TID !== 4'd7 || outStream_TLAST !== 1'b0) begin
        bad++; $display("FAIL bp_hold%0d got=%b/%h/%0d/%b exp=1/b0/7/0", k, outStream_TVALID, outStream_TDATA, outStream_TID, outStream_TLAST); end
      total++; if (in_TREADY !== 2'b00) begin bad++; $display("FAIL bp_tready%0d got=%b exp=00", k, in_TREADY); end
      tick();
    end
    wait_beats(2, 20, ok);
    tick();
    total++; if (sb.size() !== 2) begin bad++; $display("FAIL bp_count got=%0d exp=2", sb.size()); end
    if (sb.size() == 2) begin
      total++; if (sb[0].d !== 64'hB0 || sb[1].d !== 64'hB1 || sb[1].last !== 1'b1) begin
        bad++; $display("FAIL bp_data got=%h,%h exp=b0,b1", sb[0].d, sb[1].d); end
      total++; if (sb[0].cyc !== c + 5 || sb[1].cyc !== c + 6) begin
        bad++; $display("FAIL bp_timing got=%0d,%0d exp=5,6", sb[0].cyc - c, sb[1].cyc - c); end
    end
  endtask

  task automatic test_malformed();
    bit ok;
    do_reset();
    push_beat(1, 64'h5A, 4'd3, 1'b1);
    tick(); tick(); tick();
    total++; if (sb.size() !== 1 || outStream_TLAST !== 1'b1) begin bad++; $display("FAIL short_fwd got=%0d beats exp=1", sb.size()); end
    total++; if (err_short !== 1'b1 || err_long !== 1'b0) begin bad++; $display("FAIL short_flags got=%b%b exp=10", err_short, err_long); end
    total++; if (in_TREADY !== 2'b00) begin bad++; $display("FAIL short_idle got=%b exp=00", in_TREADY); end
    do_reset();
    push_beat(0, 64'hC0, 4'd9, 1'b0);
    push_beat(0, 64'hC1, 4'd9, 1'b0);
    push_beat(0, 64'hC2, 4'd9, 1'b1);
    wait_beats(3, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL long_timeout got=%0d beats exp=3", sb.size()); end
    if (ok) begin
      total++; if (sb[0].d !== 64'hC0 || sb[1].d !== 64'hC1 || sb[2].d !== 64'hC2 || sb[2].last !== 1'b1 || sb[1].last !== 1'b0) begin
        bad++; $display("FAIL long_fwd got=%h,%h,%h exp=c0,c1,c2", sb[0].d, sb[1].d, sb[2].d); end
    end
    total++; if (err_long !== 1'b1 || err_short !== 1'b0) begin bad++; $display("FAIL long_flags got=%b%b exp=01", err_short, err_long); end
  endtask

  task automatic test_starvation();
    bit ok;
    int exp_s[4] = '{0, 1, 0, 0};
    int exp_p[4] = '{0, 0, 1, 2};
    do_reset();
    for (int p = 0; p < 3; p++) begin
      push_beat(0, hdr(0, p), 4'd0, 1'b0);
      push_beat(0, hdr(0, p) | 64'h1, 4'd0, 1'b1);
    end
    tick(); tick();
    push_beat(1, hdr(1, 0), 4'd1, 1'b0);
    push_beat(1, hdr(1, 0) | 64'h1, 4'd1, 1'b1);
    wait_beats(8, 60, ok);
    total++; if (!ok) begin bad++; $display("FAIL starve_timeout got=%0d beats exp=8", sb.size()); end
    if (ok) begin
      for (int q = 0; q < 4; q++) begin
        total++; if (sb[2*q].d !== hdr(exp_s[q], exp_p[q]) || sb[2*q].id !== 4'(exp_s[q])) begin
          bad++; $display("FAIL starve_pkt%0d got=%h exp=%h", q, sb[2*q].d, hdr(exp_s[q], exp_p[q])); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c; bit ok;
    tick();
    sb.delete();
    c = cyc;
    push_beat(0, 64'hD0, 4'd4, 1'b0);
    push_beat(0, 64'hD1, 4'd4, 1'b1);
    tick(); tick(); tick();
    total++; if (outStream_TVALID !== 1'b1 || outStream_TDATA !== 64'hD0) begin
      bad++; $display("FAIL rmid_hdr got=%b/%h exp=1/d0", outStream_TVALID, outStream_TDATA); end
    ap_rst = 1'b1;
    tick();
    total++; if (outStream_TVALID !== 1'b0 || in_TREADY !== 2'b00) begin
      bad++; $display("FAIL rmid_clear got=%b/%b exp=0/00", outStream_TVALID, in_TREADY); end
    total++; if ({err_short, err_long} !== 2'b00) begin bad++; $display("FAIL rmid_flags got=%b exp=00", {err_short, err_long}); end
    ap_rst = 1'b0;
    srcq[0].delete();
    sb.delete();
    c = cyc;
    push_beat(0, 64'hE0, 4'd6, 1'b0);
    push_beat(0, 64'hE1, 4'd6, 1'b1);
    wait_beats(2, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL rmid_timeout got=%0d beats exp=2", sb.size()); end
    if (ok) begin
      total++; if (sb[0].d !== 64'hE0 || sb[1].d !== 64'hE1 || sb[1].last !== 1'b1 || sb[0].cyc !== c + 3) begin
        bad++; $display("FAIL rmid_after got=%h,%h@%0d exp=e0,e1@3", sb[0].d, sb[1].d, sb[0].cyc - c); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_starvation();
    test_malformed();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
